// File: rtl/mult_pkg.sv
// Shared definitions for the shift-add multiplier controller: state encoding,
// default operand width and the iteration-counter width helper.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADD   = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam int DEFAULT_WIDTH = 4;

    // The counter must be able to hold WIDTH itself, not just WIDTH-1.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/mult_ctrl_cnt.sv
// Loadable down-counter holding the remaining add/shift iterations (P).
// Load wins over decrement; decrement saturates at zero.
module mult_ctrl_cnt #(
    parameter int CNT_W = 3
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [CNT_W-1:0] loadVal_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] count_o,
    output logic             zero_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = loadVal_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign zero_o  = (count_q == '0);

endmodule

// File: rtl/mult_ctrl.sv
// Sequencer for the shift-add multiplier datapath: drives the B/Q load, A/G
// clear/load and G/A/Q shift strobes and owns the iteration counter P.
module mult_ctrl
    import mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = cnt_width(WIDTH)
) (
    input  logic             Mult_Ctrl_Clock,
    input  logic             Mult_Ctrl_Reset_n,
    input  logic             Mult_Ctrl_Start,
    input  logic             Mult_Ctrl_Q0,
    output logic             Mult_Ctrl_Load_BQ,
    output logic             Mult_Ctrl_Clear_AG,
    output logic             Mult_Ctrl_Load_AG,
    output logic             Mult_Ctrl_Shift,
    output logic             Mult_Ctrl_Busy,
    output logic             Mult_Ctrl_Done,
    output logic [CNT_W-1:0] Mult_Ctrl_Count
);

    state_e state_q;
    logic   accept;
    logic   cntZero;

    // Reset gates the Mealy start strobes so nothing fires while held in reset.
    assign accept = Mult_Ctrl_Reset_n && (state_q == IDLE) && Mult_Ctrl_Start;

    mult_ctrl_cnt #(
        .CNT_W(CNT_W)
    ) u_cnt (
        .clk_i     (Mult_Ctrl_Clock),
        .rst_ni    (Mult_Ctrl_Reset_n),
        .load_i    (accept),
        .loadVal_i (CNT_W'(WIDTH)),
        .dec_i     (state_q == ADD),
        .count_o   (Mult_Ctrl_Count),
        .zero_o    (cntZero)
    );

    always_ff @(posedge Mult_Ctrl_Clock or negedge Mult_Ctrl_Reset_n) begin
        if (!Mult_Ctrl_Reset_n) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE:    if (Mult_Ctrl_Start) state_q <= ADD;
                ADD:     state_q <= SHIFT;
                SHIFT:   state_q <= cntZero ? DONE : ADD;
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign Mult_Ctrl_Load_BQ  = accept;
    assign Mult_Ctrl_Clear_AG = accept;
    assign Mult_Ctrl_Load_AG  = (state_q == ADD) && Mult_Ctrl_Q0;
    assign Mult_Ctrl_Shift    = (state_q == SHIFT);
    assign Mult_Ctrl_Busy     = (state_q != IDLE);
    assign Mult_Ctrl_Done     = (state_q == DONE);

endmodule

// File: tb/tb_mult_ctrl.sv
// Self-checking bench: WIDTH=4 and WIDTH=8 controllers run in lockstep against
// a cycle-index reference model (cycles elapsed since the accept cycle).
module tb_mult_ctrl;

    logic       clock;
    logic       reset_n;
    logic       startIn;
    logic       q0In;

    logic       loadBq4, clearAg4, loadAg4, shift4, busy4, done4;
    logic [2:0] count4;
    logic       loadBq8, clearAg8, loadAg8, shift8, busy8, done8;
    logic [3:0] count8;

    int checks = 0;
    int errors = 0;
    int k4 = 0;
    int k8 = 0;
    int donePulses4 = 0;

    mult_ctrl #(.WIDTH(4)) dut4 (
        .Mult_Ctrl_Clock    (clock),
        .Mult_Ctrl_Reset_n  (reset_n),
        .Mult_Ctrl_Start    (startIn),
        .Mult_Ctrl_Q0       (q0In),
        .Mult_Ctrl_Load_BQ  (loadBq4),
        .Mult_Ctrl_Clear_AG (clearAg4),
        .Mult_Ctrl_Load_AG  (loadAg4),
        .Mult_Ctrl_Shift    (shift4),
        .Mult_Ctrl_Busy     (busy4),
        .Mult_Ctrl_Done     (done4),
        .Mult_Ctrl_Count    (count4)
    );

    mult_ctrl #(.WIDTH(8)) dut8 (
        .Mult_Ctrl_Clock    (clock),
        .Mult_Ctrl_Reset_n  (reset_n),
        .Mult_Ctrl_Start    (startIn),
        .Mult_Ctrl_Q0       (q0In),
        .Mult_Ctrl_Load_BQ  (loadBq8),
        .Mult_Ctrl_Clear_AG (clearAg8),
        .Mult_Ctrl_Load_AG  (loadAg8),
        .Mult_Ctrl_Shift    (shift8),
        .Mult_Ctrl_Busy     (busy8),
        .Mult_Ctrl_Done     (done8),
        .Mult_Ctrl_Count    (count8)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // k == 0 means idle; k == n means n cycles after the accept cycle.
    function automatic logic [5:0] expStrobes(input int w, input int k, input logic st, input logic q0);
        logic [5:0] s;
        s = 6'b0;  // {Load_BQ, Clear_AG, Load_AG, Shift, Busy, Done}
        if (k == 0) begin
            s[5] = st;
            s[4] = st;
        end else if (k <= 2 * w) begin
            s[1] = 1'b1;
            if (k % 2 == 1) s[3] = q0;
            else            s[2] = 1'b1;
        end else begin
            s[1] = 1'b1;
            s[0] = 1'b1;
        end
        return s;
    endfunction

    function automatic int expCount(input int w, input int k);
        if (k == 0 || k > 2 * w) return 0;
        if (k % 2 == 1)          return w - (k - 1) / 2;
        return w - k / 2;
    endfunction

    function automatic int nextK(input int w, input int k, input logic st);
        if (k == 0) return st ? 1 : 0;
        if (k == 2 * w + 1) return 0;
        return k + 1;
    endfunction

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic checkAll(input logic zeroExpected);
        logic [5:0] e4, e8;
        int c4, c8;
        e4 = zeroExpected ? 6'b0 : expStrobes(4, k4, startIn, q0In);
        e8 = zeroExpected ? 6'b0 : expStrobes(8, k8, startIn, q0In);
        c4 = zeroExpected ? 0 : expCount(4, k4);
        c8 = zeroExpected ? 0 : expCount(8, k8);
        checkOutput("w4_strobes", {10'b0, loadBq4, clearAg4, loadAg4, shift4, busy4, done4}, {10'b0, e4});
        checkOutput("w4_count",   {13'b0, count4}, 16'(c4));
        checkOutput("w8_strobes", {10'b0, loadBq8, clearAg8, loadAg8, shift8, busy8, done8}, {10'b0, e8});
        checkOutput("w8_count",   {12'b0, count8}, 16'(c8));
    endtask

    // One clock: drive at negedge, check Mealy outputs 1 ns later, advance model at posedge.
    task automatic applyStimulus(input logic st, input logic q0);
        @(negedge clock);
        startIn = st;
        q0In    = q0;
        #1;
        checkAll(1'b0);
        if (done4) donePulses4++;
        @(posedge clock);
        k4 = nextK(4, k4, st);
        k8 = nextK(8, k8, st);
    endtask

    initial begin
        logic [3:0] mult1101;
        mult1101 = 4'b1101;
        reset_n = 1'b0;
        startIn = 1'b0;
        q0In    = 1'b0;

        #3;
        checkAll(1'b1);
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;

        $display("[TB] idle after reset");
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'($urandom));

        $display("[TB] single multiply, multiplier 1101 (LSB first)");
        applyStimulus(1'b1, 1'($urandom));
        for (int i = 1; i <= 20; i++)
            applyStimulus(1'b0, (i % 2 == 1 && i <= 7) ? mult1101[(i - 1) / 2] : 1'($urandom));

        $display("[TB] start held high for 30 cycles");
        donePulses4 = 0;
        for (int i = 0; i < 30; i++) applyStimulus(1'b1, 1'($urandom));
        checkOutput("w4_done_pulses_held_start", 16'(donePulses4), 16'd3);
        for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'($urandom));

        $display("[TB] start pulse during shift of iteration 2");
        applyStimulus(1'b1, 1'($urandom));
        for (int i = 1; i <= 20; i++) applyStimulus(i == 4, 1'($urandom));

        $display("[TB] async reset during add of iteration 3");
        applyStimulus(1'b1, 1'($urandom));
        for (int i = 1; i <= 4; i++) applyStimulus(1'b0, 1'($urandom));
        @(negedge clock);
        startIn = 1'b0;
        q0In    = 1'b1;
        #1;
        checkAll(1'b0);
        checkOutput("w4_in_add_iter3", {15'b0, loadAg4}, 16'd1);
        #2;
        reset_n = 1'b0;
        #1;
        checkAll(1'b1);
        k4 = 0;
        k8 = 0;
        @(posedge clock);
        @(negedge clock);
        #1;
        checkAll(1'b1);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'($urandom));
        applyStimulus(1'b1, 1'($urandom));
        for (int i = 1; i <= 20; i++) applyStimulus(1'b0, 1'($urandom));

        $display("[TB] Q0 all ones");
        applyStimulus(1'b1, 1'b1);
        for (int i = 1; i <= 20; i++) applyStimulus(1'b0, 1'b1);

        $display("[TB] random start/Q0");
        for (int i = 0; i < 300; i++) applyStimulus($urandom_range(0, 7) == 0, 1'($urandom));
        for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'($urandom));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
